return_stack: RTL and testbench

- Hardware return-address stack directly upstream of the program counter.
- On a call, it captures the address of the call instruction. On a return, it presents the most recent entry as ret_data, together with the ret_f qualifier, and pops it.
- The program counter adds 1 to ret_data itself, so this stack stores the call address unmodified.
- Overflow and underflow are reported through sticky flags for debug and trap logic.

---
 rtl/return_stack.sv | 191 +++++++++++++++++++
 tb/tb_return_stack.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Return-address stack that sits just upstream of the program counter.
// A call pushes the address of the call instruction unmodified, because the
// program counter adds one to ret_data itself. A return presents the top
// entry with zero latency and pops it on the same edge. Overflow and
// underflow are latched in sticky flags for debug and trap logic.

module return_stack #(
    parameter int CNTR_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call,
    input  logic                  ret,
    input  logic [CNTR_WIDTH-1:0] pc_in,
    input  logic                  clr_err,
    output logic [CNTR_WIDTH-1:0] ret_data,
    output logic                  ret_f,
    output logic [PTR_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    // The entry index uses the low bits of the occupancy count. The extra
    // count bit exists only so that DEPTH itself can be represented.
    localparam int ADDR_WIDTH = PTR_WIDTH - 1;

    // Operation chosen for this cycle, decoded from call/ret and occupancy.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_OVERFLOW,
        OP_UNDERFLOW,
        OP_PUSH_EMPTY
    } stackOp_t;

    stackOp_t              stackOp;

    logic [CNTR_WIDTH-1:0] stackMem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  count_q;
    logic [PTR_WIDTH-1:0]  count_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  underflow_q;
    logic                  underflow_d;

    logic [PTR_WIDTH-1:0]  countMinusOne;
    logic [PTR_WIDTH-1:0]  countPlusOne;
    logic [ADDR_WIDTH-1:0] topIdx;
    logic [ADDR_WIDTH-1:0] pushIdx;
    logic                  isEmpty;
    logic                  isFull;

    logic                  memWrEn;
    logic [ADDR_WIDTH-1:0] memWrIdx;
    logic                  pushOverflow;
    logic                  popUnderflow;

    // Occupancy status and pointer arithmetic derived from the registered count.
    always_comb begin
        isEmpty       = (count_q == '0);
        isFull        = (count_q == PTR_WIDTH'(DEPTH));
        countMinusOne = count_q - PTR_WIDTH'(1);
        countPlusOne  = count_q + PTR_WIDTH'(1);
        topIdx        = countMinusOne[ADDR_WIDTH-1:0];
        pushIdx       = count_q[ADDR_WIDTH-1:0];
    end

    // Classify the request; a simultaneous call and return replaces the top,
    // except on an empty stack where it degenerates into a push.
    always_comb begin
        stackOp = OP_IDLE;
        unique case ({call, ret})
            2'b10: begin
                if (isFull) begin
                    stackOp = OP_OVERFLOW;
                end else begin
                    stackOp = OP_PUSH;
                end
            end
            2'b01: begin
                if (isEmpty) begin
                    stackOp = OP_UNDERFLOW;
                end else begin
                    stackOp = OP_POP;
                end
            end
            2'b11: begin
                if (isEmpty) begin
                    stackOp = OP_PUSH_EMPTY;
                end else begin
                    stackOp = OP_REPLACE;
                end
            end
            default: begin
                stackOp = OP_IDLE;
            end
        endcase
    end

    // Next-state for count, the storage write strobe and the error events.
    always_comb begin
        count_d      = count_q;
        memWrEn      = 1'b0;
        memWrIdx     = pushIdx;
        pushOverflow = 1'b0;
        popUnderflow = 1'b0;
        unique case (stackOp)
            OP_PUSH: begin
                memWrEn  = 1'b1;
                memWrIdx = pushIdx;
                count_d  = countPlusOne;
            end
            OP_POP: begin
                count_d = countMinusOne;
            end
            OP_REPLACE: begin
                memWrEn  = 1'b1;
                memWrIdx = topIdx;
            end
            OP_OVERFLOW: begin
                pushOverflow = 1'b1;
            end
            OP_UNDERFLOW: begin
                popUnderflow = 1'b1;
            end
            OP_PUSH_EMPTY: begin
                memWrEn      = 1'b1;
                memWrIdx     = pushIdx;
                count_d      = countPlusOne;
                popUnderflow = 1'b1;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Sticky flags: a clear is honoured unless a new error arrives the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (pushOverflow) begin
            overflow_d = 1'b1;
        end
        if (popUnderflow) begin
            underflow_d = 1'b1;
        end
    end

    // Control registers; reset empties the stack and clears the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage is deliberately left uncleared by reset; it is gated off while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && memWrEn) begin
            stackMem_q[memWrIdx] <= pc_in;
        end
    end

    // Output view: the top entry is forced to zero while the stack is empty.
    always_comb begin
        ret_data  = isEmpty ? '0 : stackMem_q[topIdx];
        ret_f     = ret & ~isEmpty;
        count     = count_q;
        empty     = isEmpty;
        full      = isFull;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack with hand-computed expectations.

module tb_return_stack;

    logic       clk;
    logic       rst;
    logic       call;
    logic       ret;
    logic [7:0] pc_in;
    logic       clr_err;
    logic [7:0] ret_data;
    logic       ret_f;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int vectorCount = 0;
    int missCount   = 0;

    return_stack #(.CNTR_WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .call      (call),
        .ret       (ret),
        .pc_in     (pc_in),
        .clr_err   (clr_err),
        .ret_data  (ret_data),
        .ret_f     (ret_f),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs; they take effect at the next step.
    task automatic applyStimulus(input logic c, input logic r, input logic [7:0] pc,
                                 input logic clr, input logic rs);
        call    = c;
        ret     = r;
        pc_in   = pc;
        clr_err = clr;
        rst     = rs;
        #1;
    endtask

    // Advance one clock edge and return the inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        call    = 1'b0;
        ret     = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b0;
        #1;
    endtask

    task automatic push(input logic [7:0] pc);
        applyStimulus(1'b1, 1'b0, pc, 1'b0, 1'b0);
        step();
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step();
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step();

        // Reset state
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_unf", underflow, 0);
        checkOutput("rst_data", ret_data, 0);
        checkOutput("rst_retf", ret_f, 0);

        // Three pushes
        push(8'h10);
        push(8'h20);
        push(8'h30);
        checkOutput("p3_count", count, 3);
        checkOutput("p3_data", ret_data, 'h30);
        checkOutput("p3_empty", empty, 0);
        checkOutput("p3_full", full, 0);

        // Three pops in LIFO order
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("pop1_data", ret_data, 'h30);
        checkOutput("pop1_retf", ret_f, 1);
        step();
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("pop2_data", ret_data, 'h20);
        checkOutput("pop2_retf", ret_f, 1);
        step();
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("pop3_data", ret_data, 'h10);
        checkOutput("pop3_retf", ret_f, 1);
        step();
        checkOutput("pop_count", count, 0);
        checkOutput("pop_empty", empty, 1);
        checkOutput("pop_data", ret_data, 0);
        checkOutput("pop_unf", underflow, 0);

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
        end
        checkOutput("fill_full", full, 1);
        checkOutput("fill_count", count, 8);
        checkOutput("fill_ovf", overflow, 0);
        push(8'h99);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_full", full, 1);
        checkOutput("ovf_count", count, 8);
        checkOutput("ovf_data", ret_data, 'h08);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("clr_ovf", overflow, 0);

        // Clear coinciding with a new overflow: the event wins
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
        step();
        checkOutput("clr_vs_ovf", overflow, 1);
        checkOutput("clr_vs_ovf_data", ret_data, 'h08);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("clr_ovf2", overflow, 0);

        // Drain the full stack, checking every entry
        for (int i = 8; i >= 1; i--) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            checkOutput("drain_data", ret_data, i);
            step();
        end
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_unf", underflow, 0);

        // Pop while empty
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("unf_retf", ret_f, 0);
        step();
        checkOutput("unf_flag", underflow, 1);
        checkOutput("unf_count", count, 0);

        // Call and ret together on an empty stack
        applyStimulus(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
        checkOutput("cr_empty_retf", ret_f, 0);
        step();
        checkOutput("cr_empty_count", count, 1);
        checkOutput("cr_empty_data", ret_data, 'h42);
        checkOutput("cr_empty_unf", underflow, 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("clr_unf", underflow, 0);

        // Replace top with call and ret together
        doReset();
        push(8'h10);
        push(8'h20);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("rep_pre_data", ret_data, 'h20);
        checkOutput("rep_pre_retf", ret_f, 1);
        step();
        checkOutput("rep_count", count, 2);
        checkOutput("rep_data", ret_data, 'h55);
        checkOutput("rep_unf", underflow, 0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("rep_below", ret_data, 'h10);
        checkOutput("rep_below_cnt", count, 1);

        // Reset mid-sequence overrides a concurrent call
        doReset();
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("pre_rst_unf", underflow, 1);
        push(8'h10);
        push(8'h20);
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        step();
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_empty", empty, 1);
        checkOutput("mid_rst_ovf", overflow, 0);
        checkOutput("mid_rst_unf", underflow, 0);
        checkOutput("mid_rst_data", ret_data, 0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("post_rst_retf", ret_f, 0);
        step();
        checkOutput("post_rst_unf", underflow, 1);
        checkOutput("post_rst_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
